i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 16: sample width per channel, two's complement.
REQ-002 Parameter SLOT_W, default 32: BCLK periods per channel slot; SLOT_W >= DATA_W+1.
REQ-003 Parameter BCLK_DIV, default 4: clk cycles per BCLK half-period, >= 2.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 audio_in  in  [1:0][DATA_W-1:0]  stereo sample from the FX chain; [0] = left, [1] = right.
REQ-007 sample_en  in  1  one-clk strobe; audio_in is valid in this cycle.
REQ-008 i2s_bclk  out  1  serial bit clock to the DAC.
REQ-009 i2s_lrck  out  1  word select; 0 = left slot, 1 = right slot.
REQ-010 i2s_sdata  out  1  serial data, MSB first, I2S one-BCLK delay.
REQ-011 frame_req  out  1  one-clk pulse at each frame load; doubles as a sample request to the upstream chain.
REQ-012 underrun  out  1  sticky; set when a frame loads with no new sample pending.
REQ-013 overrun  out  1  sticky; set when sample_en arrives while a sample is already pending.
REQ-014 clr_flags  in  1  synchronous clear of underrun and overrun.

Function
REQ-015 div_cnt counts 0..BCLK_DIV-1; i2s_bclk toggles in the clk where div_cnt = BCLK_DIV-1. BCLK period = 2*BCLK_DIV clk.
REQ-016 "Falling tick" = the clk in which i2s_bclk goes 1->0. i2s_lrck, i2s_sdata and bit_cnt update only on falling ticks.
REQ-017 bit_cnt counts 0..2*SLOT_W-1 and wraps to 0; one frame = 2*SLOT_W BCLK periods.
REQ-018 On a falling tick, i2s_lrck = 0 when the new bit_cnt < SLOT_W, else 1.
REQ-019 Channel bit mapping, using the new bit_cnt n:
  - n in 1..DATA_W: left bit DATA_W-n.
  - n in SLOT_W+1..SLOT_W+DATA_W: right bit DATA_W-(n-SLOT_W).
  - All other n: sdata = 0.
REQ-020 Holding register plus pending flag: sample_en captures audio_in into holding and sets pending.
REQ-021 Frame load occurs on the falling tick where bit_cnt wraps to 0:
  - Shift data is taken from holding.
  - pending is cleared.
  - frame_req pulses high for exactly that clk.
REQ-022 Frame load with pending = 0 replays the holding content (last sample) and sets underrun.
REQ-023 sample_en while pending = 1 overwrites holding and sets overrun.
REQ-024 sample_en in the same clk as a frame load:
  - The load uses the old holding content.
  - The new sample is written to holding; pending ends at 1.
  - overrun is not set.
  - underrun follows the old pending value.
REQ-025 clr_flags has priority over a same-cycle flag set; both flags read 0 in the following cycle.
REQ-026 Latency: a sample captured before a frame load is presented at i2s_sdata starting one BCLK after that load (left MSB at bit_cnt 1).
REQ-027 audio_in is sampled only when sample_en = 1; it is ignored at all other times.

Reset
REQ-028 While reset_n = 0, all of the following are held at 0:
  - div_cnt, holding, pending, shift data.
  - i2s_bclk, i2s_lrck, i2s_sdata.
  - frame_req, underrun, overrun.
REQ-029 While reset_n = 0, bit_cnt = 2*SLOT_W-1.
REQ-030 The first falling tick after release therefore wraps bit_cnt to 0 and performs a frame load. That tick falls 2*BCLK_DIV clk cycles after release (clk edge 8 with defaults).
REQ-031 Reset asserted mid-frame returns all state to REQ-028/REQ-029 values immediately (asynchronously); no partial frame resumes.

Structure
REQ-032 Shared package audio_pkg holds:
  - DATA_W.
  - Stereo sample typedef [1:0][DATA_W-1:0].
  - Channel index constants LEFT = 0 and RIGHT = 1.
REQ-033 The BCLK divider and tick generation live in one sub-module, i2s_bclk_gen. Outputs: i2s_bclk, fall_tick, rise_tick.
REQ-034 The shift/frame logic is in i2s_tx proper. Total RTL is under 400 lines.

Verification
REQ-035 Reset release with no samples: frame_req at clk 8, then every 512 clk; i2s_sdata stays 0; underrun = 1 after the first load.
REQ-036 Send L=16'hA5C3, R=16'h8001 before a load: the decoded left slot equals A5C3 and the right slot equals 8001, with MSBs at bit_cnt 1 and 33.
REQ-037 Two sample_en strobes (0x1111, then 0x2222) within one frame: overrun = 1 and the next frame carries 0x2222.
REQ-038 sample_en coincident with frame_req: that frame carries the previous sample, the next frame carries the new one, and overrun stays 0.
REQ-039 Assert clr_flags after REQ-035/REQ-037: both flags read 0 the following clk.
REQ-040 Assert reset_n = 0 at bit_cnt 20: all outputs read 0 within the same clk, and REQ-035 timing repeats after release.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types: default sample width, stereo sample container, channel indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

  // Default sample width per channel, two's complement.
  localparam int DATA_W = 16;

  // One stereo sample; [LEFT] is the left channel, [RIGHT] the right channel.
  typedef logic [1:0][DATA_W-1:0] stereo_t;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider: produces i2s_bclk plus single-clk edge ticks for the serialiser.
// Latency: ticks are asserted combinationally in the clk whose edge toggles i2s_bclk.
// Backpressure: none; free-running from reset release.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   i2s_bclk   divided bit clock, period 2*BCLK_DIV clk
//   fall_tick  high in the clk whose edge takes i2s_bclk 1->0
//   rise_tick  high in the clk whose edge takes i2s_bclk 0->1
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic i2s_bclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int                DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             div_wrap;

  assign div_wrap = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = bclk_q ^ div_wrap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // The tick names the edge that is about to happen on i2s_bclk.
  assign fall_tick = div_wrap &  bclk_q;
  assign rise_tick = div_wrap & ~bclk_q;
  assign i2s_bclk  = bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: holds one stereo sample and serialises it MSB-first with the I2S one-BCLK delay.
// Latency: a sample captured before a frame load appears on i2s_sdata one BCLK after that load.
// Backpressure: none; frame_req requests the next sample, underrun/overrun flag missed/extra samples.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   audio_in, sample_en   stereo sample ([0]=left, [1]=right) and its one-clk strobe
//   clr_flags             synchronous clear of underrun/overrun (wins over a same-cycle set)
//   i2s_bclk/lrck/sdata   serial outputs to the DAC
//   frame_req             one-clk pulse at each frame load
//   underrun, overrun     sticky status flags
module i2s_tx #(
  parameter int DATA_W   = audio_pkg::DATA_W,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   sample_en,
  input  logic                   clr_flags,
  output logic                   i2s_bclk,
  output logic                   i2s_lrck,
  output logic                   i2s_sdata,
  output logic                   frame_req,
  output logic                   underrun,
  output logic                   overrun
);
  import audio_pkg::*;

  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_START = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] L_FIRST    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_LAST     = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] R_FIRST    = CNT_W'(SLOT_W + 1);
  localparam logic [CNT_W-1:0] R_LAST     = CNT_W'(SLOT_W + DATA_W);

  logic                   fall_tick;
  logic                   rise_tick_unused;
  logic                   load;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [CNT_W-1:0]       l_off, r_off;
  logic [1:0][DATA_W-1:0] holding_q, holding_d;
  logic [1:0][DATA_W-1:0] shift_q, shift_d;
  logic                   pending_q, pending_d;
  logic                   lrck_q, lrck_d;
  logic                   sdata_q, sdata_d;
  logic                   frame_req_q, frame_req_d;
  logic                   underrun_q, underrun_d;
  logic                   overrun_q, overrun_d;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2s_bclk  (i2s_bclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick_unused)
  );

  // A frame loads on the falling tick where the bit counter wraps.
  assign load    = fall_tick && (bit_cnt_q == CNT_LAST);
  assign bit_nxt = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;

  // Bit position within each channel word for the upcoming bit_cnt, MSB first.
  assign l_off = L_LAST - bit_nxt;
  assign r_off = R_LAST - bit_nxt;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    if (fall_tick) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = (bit_nxt >= SLOT_START);
      sdata_d   = 1'b0;
      if (bit_nxt >= L_FIRST && bit_nxt <= L_LAST) begin
        sdata_d = shift_q[LEFT][l_off[IDX_W-1:0]];
      end else if (bit_nxt >= R_FIRST && bit_nxt <= R_LAST) begin
        sdata_d = shift_q[RIGHT][r_off[IDX_W-1:0]];
      end
    end

    // The load always reads the old holding value, so a coincident sample_en
    // lands in holding for the following frame.
    shift_d     = load ? holding_q : shift_q;
    holding_d   = sample_en ? audio_in : holding_q;
    pending_d   = sample_en | (pending_q & ~load);
    frame_req_d = load;

    // A sample arriving exactly at a load is consumed-by-next-frame, not an overrun.
    underrun_d  = ~clr_flags & (underrun_q | (load & ~pending_q));
    overrun_d   = ~clr_flags & (overrun_q  | (sample_en & pending_q & ~load));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q   <= CNT_LAST;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      shift_q     <= '0;
      holding_q   <= '0;
      pending_q   <= 1'b0;
      frame_req_q <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      shift_q     <= shift_d;
      holding_q   <= holding_d;
      pending_q   <= pending_d;
      frame_req_q <= frame_req_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign i2s_lrck  = lrck_q;
  assign i2s_sdata = sdata_q;
  assign frame_req = frame_req_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx with default parameters.
// A DAC-style receiver decodes each frame on BCLK rising edges; expected frame
// contents come from the rule "last sample handed over before the load".
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int SLOT       = 32;
  localparam int DIV        = 4;
  localparam int FRAME_CLKS = 2 * SLOT * 2 * DIV;
  localparam int FIRST_LOAD = 2 * DIV;

  logic    clk       = 1'b0;
  logic    reset_n   = 1'b0;
  stereo_t audio_in  = '0;
  logic    sample_en = 1'b0;
  logic    clr_flags = 1'b0;
  logic    i2s_bclk, i2s_lrck, i2s_sdata, frame_req, underrun, overrun;

  int n_vec = 0;
  int n_err = 0;

  int unsigned cyc     = 0;
  int unsigned rel_cyc = 0;
  logic [15:0] last_l  = '0;
  logic [15:0] last_r  = '0;

  always #5 clk = ~clk;

  i2s_tx #(.DATA_W(16), .SLOT_W(SLOT), .BCLK_DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .audio_in  (audio_in),
    .sample_en (sample_en),
    .clr_flags (clr_flags),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata),
    .frame_req (frame_req),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- receiver ----------------
  logic [15:0] dec_l[$];
  logic [15:0] dec_r[$];
  bit          dec_bad[$];
  int          ones_cnt = 0;
  bit          mon_active = 1'b0;
  int          mon_p = 0;
  logic        prev_bclk = 1'b0;
  logic [63:0] mon_bits;
  logic [63:0] mon_lr;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_active = 1'b0;
      mon_p      = 0;
      prev_bclk  = 1'b0;
    end else begin
      if (i2s_sdata === 1'b1) ones_cnt++;
      if (i2s_bclk === 1'b1 && prev_bclk === 1'b0 && mon_active) begin
        mon_bits[mon_p] = i2s_sdata;
        mon_lr[mon_p]   = i2s_lrck;
        mon_p++;
        if (mon_p == 2 * SLOT) begin
          logic [15:0] l, r;
          bit bad;
          l = '0; r = '0; bad = 1'b0;
          for (int i = 1; i <= 16; i++) l = {l[14:0], mon_bits[i]};
          for (int i = SLOT + 1; i <= SLOT + 16; i++) r = {r[14:0], mon_bits[i]};
          for (int p = 0; p < 2 * SLOT; p++) begin
            if (!((p >= 1 && p <= 16) || (p >= SLOT + 1 && p <= SLOT + 16)) && mon_bits[p] !== 1'b0)
              bad = 1'b1;
            if (mon_lr[p] !== ((p >= SLOT) ? 1'b1 : 1'b0)) bad = 1'b1;
          end
          dec_l.push_back(l);
          dec_r.push_back(r);
          dec_bad.push_back(bad);
          mon_active = 1'b0;
        end
      end
      prev_bclk = i2s_bclk;
      if (frame_req === 1'b1) begin
        mon_active = 1'b1;
        mon_p      = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic int tcyc();
    return int'(cyc - rel_cyc);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    audio_in[LEFT]  = l;
    audio_in[RIGHT] = r;
    sample_en       = 1'b1;
    @(negedge clk);
    sample_en       = 1'b0;
    audio_in        = stereo_t'($urandom);
    last_l          = l;
    last_r          = r;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic wait_fr(input string nm, output int t);
    t = -1;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (frame_req === 1'b1) begin
        t = tcyc();
        break;
      end
    end
    if (t < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no frame_req within 1200 clk", nm);
    end
  endtask

  task automatic check_frame(input string nm, input int idx, input logic [15:0] el, input logic [15:0] er);
    n_vec++;
    if (dec_l.size() <= idx) begin
      n_err++;
      $display("FAIL %s: frame %0d not decoded (have %0d)", nm, idx, dec_l.size());
    end else if (dec_l[idx] !== el || dec_r[idx] !== er || dec_bad[idx] !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got L=%h R=%h bad=%0b, want L=%h R=%h bad=0",
               nm, dec_l[idx], dec_r[idx], dec_bad[idx], el, er);
    end
  endtask

  // Reset-release behaviour with no samples: load timing, silence, underrun.
  task automatic idle_sequence(input string nm);
    int t, base, ones0;
    base  = dec_l.size();
    ones0 = ones_cnt;
    tick(FIRST_LOAD - 1);
    n_vec++;
    if ({frame_req, underrun, overrun} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_preload: fr/ur/or=%b want 000", nm, {frame_req, underrun, overrun});
    end
    for (int k = 0; k < 3; k++) begin
      wait_fr(nm, t);
      n_vec++;
      if (t != FIRST_LOAD + k * FRAME_CLKS) begin
        n_err++;
        $display("FAIL %s_load%0d_time: got clk %0d want %0d", nm, k, t, FIRST_LOAD + k * FRAME_CLKS);
      end
      if (k == 0) begin
        n_vec++;
        if (underrun !== 1'b1) begin
          n_err++;
          $display("FAIL %s_underrun: got %b want 1", nm, underrun);
        end
      end
    end
    check_frame({nm, "_frame0"}, base, 16'h0000, 16'h0000);
    check_frame({nm, "_frame1"}, base + 1, 16'h0000, 16'h0000);
    n_vec++;
    if (ones_cnt != ones0) begin
      n_err++;
      $display("FAIL %s_sdata_quiet: saw %0d high sdata clks want 0", nm, ones_cnt - ones0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    send(16'hFFFF, 16'hFFFF);
    clr_flags = 1'b1;
    tick(2);
    clr_flags = 1'b0;
    n_vec++;
    if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_req, underrun, overrun} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000",
               {i2s_bclk, i2s_lrck, i2s_sdata, frame_req, underrun, overrun});
    end
  endtask

  task automatic test_idle();
    tick(1);
    reset_n = 1'b1;
    rel_cyc = cyc;
    idle_sequence("idle");
  endtask

  task automatic test_clr(input string nm);
    pulse_clr();
    n_vec++;
    if ({underrun, overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL %s: ur/or=%b want 00", nm, {underrun, overrun});
    end
  endtask

  task automatic test_pattern();
    int t, base;
    send(16'hA5C3, 16'h8001);
    wait_fr("pattern", t);
    base = dec_l.size();
    n_vec++;
    if (underrun !== 1'b0) begin
      n_err++;
      $display("FAIL pattern_no_underrun: got %b want 0", underrun);
    end
    wait_fr("pattern", t);
    check_frame("pattern_frame", base, 16'hA5C3, 16'h8001);
  endtask

  task automatic test_overrun();
    int t, base;
    pulse_clr();
    send(16'h1111, 16'h1111);
    tick(20);
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_single: got %b want 0", overrun);
    end
    send(16'h2222, 16'h2222);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_double: got %b want 1", overrun);
    end
    wait_fr("overrun", t);
    base = dec_l.size();
    wait_fr("overrun", t);
    check_frame("overrun_frame", base, 16'h2222, 16'h2222);
  endtask

  task automatic test_coincident();
    int t, base, next_load;
    send(16'h3C3C, 16'hC3C3);
    next_load = FIRST_LOAD + ((tcyc() - FIRST_LOAD) / FRAME_CLKS + 1) * FRAME_CLKS;
    while (tcyc() < next_load - 1) @(negedge clk);
    audio_in[LEFT]  = 16'h7E01;
    audio_in[RIGHT] = 16'h0FF0;
    sample_en       = 1'b1;
    @(negedge clk);
    sample_en       = 1'b0;
    audio_in        = stereo_t'($urandom);
    n_vec++;
    if (frame_req !== 1'b1) begin
      n_err++;
      $display("FAIL coincident_frame_req: got %b want 1 at clk %0d", frame_req, tcyc());
    end
    base = dec_l.size();
    n_vec++;
    if ({underrun, overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL coincident_flags: ur/or=%b want 00", {underrun, overrun});
    end
    wait_fr("coincident", t);
    n_vec++;
    if ({underrun, overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL coincident_next_flags: ur/or=%b want 00", {underrun, overrun});
    end
    wait_fr("coincident", t);
    check_frame("coincident_old", base, 16'h3C3C, 16'hC3C3);
    check_frame("coincident_new", base + 1, 16'h7E01, 16'h0FF0);
    last_l = 16'h7E01;
    last_r = 16'h0FF0;
  endtask

  task automatic test_random();
    int t, c, base;
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    bit ue, oe;
    pulse_clr();
    base = dec_l.size();
    ue = 1'b0;
    oe = 1'b0;
    for (int f = 0; f < 8; f++) begin
      c = (f == 0) ? 2 : (f == 1) ? 0 : int'($urandom_range(0, 2));
      if (c == 0) ue = 1'b1;
      if (c == 2) oe = 1'b1;
      for (int j = 0; j < c; j++) begin
        tick(int'($urandom_range(5, 150)));
        send(16'($urandom), 16'($urandom));
      end
      wait_fr("random", t);
      exp_l.push_back(last_l);
      exp_r.push_back(last_r);
    end
    n_vec++;
    if ({underrun, overrun} !== {ue, oe}) begin
      n_err++;
      $display("FAIL random_flags: ur/or=%b want %b", {underrun, overrun}, {ue, oe});
    end
    wait_fr("random", t);
    for (int i = 0; i < 8; i++) check_frame("random_frame", base + 1 + i, exp_l[i], exp_r[i]);
  endtask

  task automatic test_midreset();
    n_vec++;
    if (underrun !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre_underrun: got %b want 1", underrun);
    end
    tick(165);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({i2s_bclk, i2s_lrck, i2s_sdata, frame_req, underrun, overrun} !== 6'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b want 000000",
               {i2s_bclk, i2s_lrck, i2s_sdata, frame_req, underrun, overrun});
    end
    tick(3);
    reset_n = 1'b1;
    rel_cyc = cyc;
    idle_sequence("midreset");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_clr("clr_after_idle");
    test_pattern();
    test_overrun();
    test_clr("clr_after_overrun");
    test_coincident();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
